// File: rtl/uart_pkg.sv
// uart_pkg: shared mode/state encodings and the pop-side byte transform
package uart_pkg;
    localparam int XF_W = 32;
    typedef enum logic [1:0] {ECHO = 2'd0, CASESWAP = 2'd1, INVERT = 2'd2} mode_e;
    typedef enum logic [1:0] {IDLE, LAUNCH, DRAIN} state_e;
    // Works on a zero-extended word so any DATA_W up to XF_W can share it;
    // unknown modes fall through to a verbatim echo.
    function automatic logic [XF_W-1:0] transform(input logic [XF_W-1:0] d, input int mode);
        logic alpha;
        alpha = (d >= 32'h41 && d <= 32'h5A) || (d >= 32'h61 && d <= 32'h7A);
        return (mode == int'(CASESWAP)) ? (alpha ? d ^ 32'h20 : d) :
               (mode == int'(INVERT)) ? ~d : d;
    endfunction
endpackage

// File: rtl/uart_echo_fifo_sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count, power-of-two depth
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic                     pop_i,
    output logic [DATA_W-1:0]        rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0] level_q;
    logic do_push, do_pop;
    assign full_o  = level_q == (AW+1)'(DEPTH);
    assign empty_o = level_q == '0;
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign rdata_o = mem_q[rd_q];
    assign level_o = level_q;
    // storage needs no reset: the level gates every read
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end
    // pointers wrap on their own because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            wr_q    <= wr_q + AW'(do_push);
            rd_q    <= rd_q + AW'(do_pop);
            level_q <= level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/uart_echo_fifo.sv
// uart_echo_fifo: buffers received bytes and echoes them through a send/busy handshake
module uart_echo_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16,
    parameter int MODE    = 0,
    parameter int CNT_W   = 8,
    parameter int BUSY_TO = 16
) (
    input  logic                   hwclk,
    input  logic                   rst,
    input  logic [DATA_W-1:0]      rx_data,
    input  logic                   rx_ready,
    output logic [DATA_W-1:0]      tx_data,
    output logic                   tx_send,
    input  logic                   tx_busy,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   overflow,
    input  logic                   ovf_clr,
    output logic [CNT_W-1:0]       drop_count,
    output logic                   led
);
    localparam int TW = $clog2(BUSY_TO + 1);
    state_e state_q, state_d;
    logic rx_q, push_req, drop, full, empty, pop, led_q, ovf_q, tx_send_q, tx_send_d;
    logic [CNT_W-1:0] drop_q;
    logic [TW-1:0] to_q, to_d;
    logic [DATA_W-1:0] head, tx_data_q, tx_data_d;
    assign push_req   = rx_ready & ~rx_q;
    assign drop       = push_req & full;
    assign tx_data    = tx_data_q;
    assign tx_send    = tx_send_q;
    assign overflow   = ovf_q;
    assign drop_count = drop_q;
    assign led        = led_q;
    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk(hwclk), .rst(rst), .push_i(push_req), .wdata_i(rx_data), .pop_i(pop),
        .rdata_o(head), .full_o(full), .empty_o(empty), .level_o(fifo_level)
    );
    // rx edge detect plus accept/drop bookkeeping; a clear beats a same-cycle drop
    always_ff @(posedge hwclk) begin
        if (rst) begin
            rx_q   <= 1'b0;
            led_q  <= 1'b0;
            ovf_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            rx_q   <= rx_ready;
            led_q  <= led_q ^ (push_req & ~full);
            ovf_q  <= ~ovf_clr & (ovf_q | drop);
            drop_q <= ovf_clr ? '0 : drop_q + CNT_W'(drop & ~&drop_q);
        end
    end
    // send FSM state and tx registers
    always_ff @(posedge hwclk) begin
        if (rst) begin
            state_q   <= IDLE;
            to_q      <= '0;
            tx_data_q <= '0;
            tx_send_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            to_q      <= to_d;
            tx_data_q <= tx_data_d;
            tx_send_q <= tx_send_d;
        end
    end
    // pop and launch from IDLE, wait for busy (or give up) in LAUNCH, wait for idle in DRAIN
    always_comb begin
        state_d   = state_q;
        to_d      = to_q;
        tx_data_d = tx_data_q;
        tx_send_d = 1'b0;
        pop       = 1'b0;
        case (state_q)
            IDLE: if (!empty) begin
                pop       = 1'b1;
                tx_data_d = DATA_W'(transform(XF_W'(head), MODE));
                tx_send_d = 1'b1;
                to_d      = '0;
                state_d   = LAUNCH;
            end
            LAUNCH: begin
                to_d    = to_q + 1'b1;
                state_d = tx_busy ? DRAIN : (to_d == TW'(BUSY_TO)) ? IDLE : LAUNCH;
            end
            DRAIN: state_d = tx_busy ? DRAIN : IDLE;
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_echo_fifo.sv
// tb_uart_echo_fifo: directed/random checks of the echo FIFO across all transform modes
module tb_uart_echo_fifo;
    localparam int DEPTH = 16, BUSY_TO = 16, FRAME = 5;
    logic hwclk = 0, rst = 1, rx_ready = 0, ovf_clr = 0;
    logic force_busy = 0, model_busy = 0, auto_tx = 1, prev_led = 0;
    logic [7:0] rx_data = 0;
    logic tx_busy;
    logic [7:0] tx_data [4];
    logic tx_send [4], overflow [4], led [4];
    logic [4:0] fifo_level [4];
    logic [7:0] drop_count [4];
    int n_chk = 0, n_fail = 0, cyc = 0, led_tog = 0;
    logic [31:0] sent [$];
    int send_cyc [$];
    logic [7:0] exp_q [$];
    logic [7:0] mq [$];
    assign tx_busy = force_busy | model_busy;
    always #5 hwclk = ~hwclk;
    for (genvar g = 0; g < 4; g++) begin : g_dut
        uart_echo_fifo #(.DATA_W(8), .DEPTH(DEPTH), .MODE(g), .CNT_W(8), .BUSY_TO(BUSY_TO)) u_dut (
            .hwclk(hwclk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready),
            .tx_data(tx_data[g]), .tx_send(tx_send[g]), .tx_busy(tx_busy),
            .fifo_level(fifo_level[g]), .overflow(overflow[g]), .ovf_clr(ovf_clr),
            .drop_count(drop_count[g]), .led(led[g])
        );
    end
    initial forever begin
        @(posedge hwclk);
        cyc++;
    end
    // capture every launched byte (all four modes share timing) and count led toggles
    initial forever begin
        @(negedge hwclk);
        if (tx_send[0]) begin
            sent.push_back({tx_data[3], tx_data[2], tx_data[1], tx_data[0]});
            send_cyc.push_back(cyc);
        end
        if (led[0] !== prev_led) led_tog++;
        prev_led = led[0];
    end
    // transmitter: busy for FRAME cycles after each send pulse
    initial forever begin
        @(negedge hwclk);
        if (auto_tx && tx_send[0]) begin
            model_busy = 1;
            repeat (FRAME) @(negedge hwclk);
            model_busy = 0;
        end
    end
    function automatic logic [7:0] ref_xf(int mode, logic [7:0] b);
        if (mode == 1 && b >= "A" && b <= "Z") return b + 8'd32;
        if (mode == 1 && b >= "a" && b <= "z") return b - 8'd32;
        if (mode == 2) return 8'hFF - b;
        return b;
    endfunction
    function automatic logic [31:0] ref_word(logic [7:0] b);
        return {ref_xf(3, b), ref_xf(2, b), ref_xf(1, b), ref_xf(0, b)};
    endfunction
    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask
    task automatic push(logic [7:0] b);
        @(posedge hwclk); #1 rx_data = b; rx_ready = 1;
        @(posedge hwclk); #1 rx_ready = 0;
    endtask
    task automatic wait_sent(string tag, int n);
        int t = 0;
        while (sent.size() < n && t < 3000) begin
            @(negedge hwclk);
            t++;
        end
        repeat (FRAME + 4) @(negedge hwclk);
        check(tag, sent.size(), n);
    endtask
    task automatic check_sent(string tag);
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s[%0d]", tag, i), (i < sent.size()) ? sent[i] : 32'hx, ref_word(exp_q[i]));
    endtask
    task automatic check_zero(string tag);
        check({tag, "_tx_data"}, tx_data[0], 0);
        check({tag, "_tx_send"}, tx_send[0], 0);
        check({tag, "_level"}, fifo_level[0], 0);
        check({tag, "_overflow"}, overflow[0], 0);
        check({tag, "_drop"}, drop_count[0], 0);
        check({tag, "_led"}, led[0], 0);
    endtask
    initial begin
        int drops, tog0;
        logic [7:0] b;
        repeat (3) @(posedge hwclk);
        @(negedge hwclk);
        check_zero("reset");
        @(posedge hwclk); #1 rst = 0;
        // single byte latency: push at E0, pop at E1, send visible for one cycle after E1
        sent.delete();
        push(8'h41);
        @(negedge hwclk);
        check("lat_e0_send", tx_send[0], 0);
        check("lat_e0_level", fifo_level[0], 1);
        @(negedge hwclk);
        check("lat_send", tx_send[0], 1);
        check("lat_data", {tx_data[3], tx_data[2], tx_data[1], tx_data[0]}, ref_word(8'h41));
        check("lat_level", fifo_level[0], 0);
        check("lat_led", led[0], 1);
        @(negedge hwclk);
        check("lat_send_low", tx_send[0], 0);
        wait_sent("lat_count", 1);
        // transform edge bytes plus random bytes, all modes in parallel
        sent.delete();
        exp_q = '{8'h61, 8'h5A, 8'h40, 8'h7B, 8'h5B, 8'h60, 8'hA5};
        repeat (9) exp_q.push_back(8'($urandom));
        foreach (exp_q[i]) push(exp_q[i]);
        wait_sent("xf_count", exp_q.size());
        check_sent("xf");
        check("xf_no_ovf", overflow[0], 0);
        // overflow: park FSM in DRAIN, then push DEPTH+3 bytes
        sent.delete();
        force_busy = 1;
        b = 8'($urandom);
        exp_q = '{b};
        push(b);
        repeat (4) @(negedge hwclk);
        tog0 = led_tog;
        mq = {};
        drops = 0;
        repeat (DEPTH + 3) begin
            b = 8'($urandom);
            push(b);
            if (mq.size() < DEPTH) mq.push_back(b);
            else drops++;
        end
        @(negedge hwclk);
        check("ovf_level", fifo_level[0], mq.size());
        check("ovf_flag", overflow[0], 1);
        check("ovf_drops", drop_count[0], drops);
        check("ovf_led_toggles", led_tog - tog0, mq.size());
        exp_q = {exp_q, mq};
        force_busy = 0;
        wait_sent("ovf_count", exp_q.size());
        check_sent("ovf_order");
        @(posedge hwclk); #1 ovf_clr = 1;
        @(posedge hwclk); #1 ovf_clr = 0;
        @(negedge hwclk);
        check("clr_flag", overflow[0], 0);
        check("clr_drops", drop_count[0], 0);
        // a long rx_ready level yields one push regardless of later data
        sent.delete();
        tog0 = led_tog;
        b = 8'($urandom);
        exp_q = '{b};
        @(posedge hwclk); #1 rx_data = b; rx_ready = 1;
        repeat (50) begin
            @(posedge hwclk); #1 rx_data = 8'($urandom);
        end
        rx_ready = 0;
        wait_sent("hold_count", 1);
        check_sent("hold");
        check("hold_led_toggles", led_tog - tog0, 1);
        // same-cycle push and pop at level 5
        sent.delete();
        force_busy = 1;
        exp_q = {};
        repeat (6) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            push(b);
        end
        @(negedge hwclk);
        check("pp_level_before", fifo_level[0], 5);
        b = 8'($urandom);
        exp_q.push_back(b);
        @(posedge hwclk); #1 force_busy = 0;
        @(posedge hwclk); #1 rx_data = b; rx_ready = 1;
        @(posedge hwclk); #1 rx_ready = 0;
        @(negedge hwclk);
        check("pp_level_after", fifo_level[0], 5);
        check("pp_send", tx_send[0], 1);
        wait_sent("pp_count", exp_q.size());
        check_sent("pp_order");
        // busy never rises: give up after BUSY_TO cycles, then one IDLE decision cycle
        sent.delete();
        send_cyc.delete();
        auto_tx = 0;
        exp_q = '{8'($urandom), 8'($urandom)};
        push(exp_q[0]);
        push(exp_q[1]);
        wait_sent("to_count", 2);
        check_sent("to");
        check("to_gap", send_cyc[1] - send_cyc[0], BUSY_TO + 1);
        repeat (BUSY_TO) @(negedge hwclk);
        auto_tx = 1;
        exp_q.push_back(8'($urandom));
        push(exp_q[2]);
        wait_sent("to_next_count", 3);
        check_sent("to_next");
        // reset while draining with three bytes queued
        force_busy = 1;
        repeat (4) push(8'($urandom));
        @(negedge hwclk);
        check("rst_level_before", fifo_level[0], 3);
        @(posedge hwclk); #1 rst = 1;
        @(posedge hwclk); #1 rst = 0;
        @(negedge hwclk);
        check_zero("rst_drain");
        force_busy = 0;
        sent.delete();
        exp_q = '{8'($urandom)};
        push(exp_q[0]);
        @(negedge hwclk);
        check("rst_idle_e0", tx_send[0], 0);
        @(negedge hwclk);
        check("rst_idle_send", tx_send[0], 1);
        wait_sent("rst_count", 1);
        check_sent("rst_data");
        // saturate the drop counter, then clear it against a same-cycle drop
        force_busy = 1;
        drops = 0;
        repeat (DEPTH + 1 + 257) begin
            push(8'($urandom));
            if (fifo_level[0] == DEPTH && tx_busy) drops = (drops == 255) ? 255 : drops + 1;
        end
        @(negedge hwclk);
        check("sat_drops", drop_count[0], 255);
        check("sat_flag", overflow[0], 1);
        @(posedge hwclk); #1 rx_data = 8'($urandom); rx_ready = 1; ovf_clr = 1;
        @(posedge hwclk); #1 rx_ready = 0; ovf_clr = 0;
        @(negedge hwclk);
        check("clrdrop_drops", drop_count[0], 0);
        check("clrdrop_flag", overflow[0], 0);
        push(8'($urandom));
        @(negedge hwclk);
        check("after_clr_drops", drop_count[0], 1);
        check("after_clr_flag", overflow[0], 1);
        check("after_clr_level", fifo_level[0], DEPTH);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_echo_fifo.md
Name: uart_echo_fifo

Overview:
Single-clock UART echo controller that sits between the existing uart_rx_8n1 and uart_tx_8n1 instances in a top level. Received bytes are buffered in a parametrised FIFO and retransmitted back to back through a proper send/busy handshake. The block adds an optional byte transform, overflow detection with a saturating drop counter, FIFO level reporting and an activity LED. All logic runs on hwclk; nothing is clocked by the rx strobe.

Parameters:
DATA_W, 8, width of rx/tx data.
DEPTH, 16, FIFO entries; must be a power of two, at least 2.
MODE, 0, transform applied on pop: 0 = verbatim echo, 1 = ASCII case swap (XOR 0x20 only when the byte is in A-Z or a-z), 2 = bitwise complement.
CNT_W, 8, drop counter width.
BUSY_TO, 16, cycles to wait for tx_busy to rise before abandoning a send.

Ports:
hwclk  in  1  system clock (12 MHz)
rst  in  1  synchronous reset, active high
rx_data  in  DATA_W  byte from receiver, valid while rx_ready is high
rx_ready  in  1  receiver ready level/strobe; one byte per rising edge
tx_data  out  DATA_W  byte to transmitter, held stable from send until busy falls
tx_send  out  1  one-cycle send pulse (transmitter enable)
tx_busy  in  1  transmitter busy
fifo_level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: a byte was dropped
ovf_clr  in  1  clears overflow and drop_count
drop_count  out  CNT_W  dropped bytes, saturating at all ones
led  out  1  toggles once per accepted byte

Behaviour:
- Reset (synchronous, active high) drives all outputs to 0: tx_data, tx_send, fifo_level, overflow, drop_count, led. It also empties the FIFO, sets the FSM to IDLE and clears the rx_ready edge register. A reset in any FSM state aborts the send in progress; an already launched tx frame completes on its own.
- Rx capture: rx_ready is registered as rx_q. A push request is rx_ready & ~rx_q. A level held high for many cycles yields exactly one push.
- Push when not full: rx_data is written at the write pointer on that edge, level increments and led toggles.
- Push when full: the byte is discarded, overflow is set, drop_count increments (saturating) and led does not toggle.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full is level==DEPTH; empty is level==0.
- A simultaneous push and pop in the same cycle leaves level unchanged and both operations succeed. When full, a same-cycle pop does not make room for that push, so the byte is dropped.
- ovf_clr wins over a same-cycle drop: both counters clear and that drop is not counted.
- FSM states:
  - IDLE: if the FIFO is not empty, pop the head, load tx_data with transform(head), assert tx_send for the next cycle and go to LAUNCH.
  - LAUNCH: tx_send deasserts (so it is exactly 1 cycle high). If tx_busy=1, go to DRAIN. Otherwise increment a timeout counter; on reaching BUSY_TO, go to IDLE.
  - DRAIN: wait for tx_busy=0, then go to IDLE. No gap cycle beyond the IDLE decision is required.
- Latency, empty FIFO and IDLE: rx edge sampled at clock edge E0, pop at E1, tx_send high during the cycle after E1. The rx edge to tx_send delay is 2 cycles.
- Back to back: the next tx_send occurs 1 cycle after tx_busy is sampled low.
- tx_data is never changed outside an IDLE pop.
- The transform is combinational on the FIFO read data and applied only at pop; the FIFO stores raw bytes. Bytes 0x40, 0x5B, 0x60 and 0x7B pass unchanged in MODE 1.
- An illegal MODE value behaves as MODE 0.

Decomposition:
- Shared package uart_pkg holds the MODE encodings (ECHO, CASESWAP, INVERT) and the FSM state typedef (IDLE, LAUNCH, DRAIN).
- Natural sub-module: sync_fifo (parametrised DATA_W/DEPTH; push, pop, full, empty, level, single clock, synchronous reset), reusable for the planned FFT sample buffering.
- The transform function lives in uart_pkg.

Test Plan:
- Reset, then a single rx_ready pulse with rx_data=0x41 and MODE 0 -> tx_send 1 cycle high exactly 2 cycles later, tx_data=0x41, led=1, fifo_level back to 0.
- MODE 1 with bytes 0x61, 0x5A, 0x40, 0x7B -> transmitted 0x41, 0x7A, 0x40, 0x7B in order; MODE 2 with 0xA5 -> 0x5A.
- Hold tx_busy high and push DEPTH+3 bytes -> fifo_level=16, overflow=1, drop_count=3, led toggled 16 times. Release tx_busy -> all 16 bytes transmitted in FIFO order.
- Hold rx_ready high for 50 cycles -> exactly one push. Push and pop in the same cycle at level 5 -> level stays 5.
- tx_busy tied to 0 after a push -> FSM returns to IDLE after BUSY_TO=16 cycles and the byte counts as sent. Next byte proceeds normally.
- Assert rst while in DRAIN with 3 bytes queued -> next cycle all outputs 0, level 0, state IDLE. ovf_clr with drop_count=255 and a same-cycle drop -> drop_count=0.
